// File: rtl/hazard_flush_controller.sv
// -----------------------------------------------------------------------------
// hazard_flush_controller
//
// Decode-stage sequencing controller. Each cycle it decides whether the
// instruction in ID must stall on a RAW hazard against the EXE/MEM destinations,
// or whether IF must be flushed because ID holds an accepted taken branch.
// A small FSM stretches the IF flush over BR_FLUSH_CYCLES cycles. Saturating
// event counters record stalls and accepted branches for debug.
//
// State | meaning
// ------+---------------------------------------------------------------
// RUN   | normal issue, no stall in progress
// STALL | previous cycle stalled on a RAW hazard
// FLUSH | extra IF flush cycles after an accepted taken branch
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ID_Valid           ID holds a real instruction
//   src1, src2         ID source registers
//   Two_Src            ID instruction actually reads src2
//   Br_Taken           ID instruction is a taken branch
//   Forward_EN         forwarding unit active (only load-use stalls)
//   EXE_Dest/WB_EN/MEM_R_EN, MEM_Dest/WB_EN   downstream destinations
//   Hazard_Detected    freeze PC and IF/ID, bubble into ID/EXE
//   IF_Flush           squash the instruction in IF/ID
//   State              FSM state (RUN=0, STALL=1, FLUSH=2)
//   Stall_Count        saturating count of stall cycles
//   Flush_Count        saturating count of accepted taken branches
// -----------------------------------------------------------------------------
module hazard_flush_controller #(
  parameter int BR_FLUSH_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_Valid,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic             Two_Src,
  input  logic             Br_Taken,
  input  logic             Forward_EN,
  input  logic [4:0]       EXE_Dest,
  input  logic             EXE_WB_EN,
  input  logic             EXE_MEM_R_EN,
  input  logic [4:0]       MEM_Dest,
  input  logic             MEM_WB_EN,
  output logic             Hazard_Detected,
  output logic             IF_Flush,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Branch accept cycle is the first flush cycle, so the FSM only covers
  // the remaining BR_FLUSH_CYCLES-1 cycles (fc counts down to zero).
  localparam logic [2:0]       FC_INIT = 3'(BR_FLUSH_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state_q;
  logic [2:0] fc_q;

  logic exe_en;
  logic exe_match;
  logic mem_match;
  logic hz;
  logic in_flush;
  logic br_acc;

  // With forwarding on, only a load in EXE cannot be bypassed in time.
  assign exe_en    = Forward_EN ? (EXE_WB_EN && EXE_MEM_R_EN) : EXE_WB_EN;
  assign exe_match = exe_en && (EXE_Dest != 5'd0) &&
                     ((EXE_Dest == src1) || (Two_Src && (EXE_Dest == src2)));
  assign mem_match = !Forward_EN && MEM_WB_EN && (MEM_Dest != 5'd0) &&
                     ((MEM_Dest == src1) || (Two_Src && (MEM_Dest == src2)));
  assign hz        = exe_match || mem_match;

  assign in_flush        = (state_q == ST_FLUSH);
  assign Hazard_Detected = !rst && hz && ID_Valid && !in_flush;
  // A stalled branch waits for its operands before it is accepted.
  assign br_acc          = !rst && Br_Taken && ID_Valid && !Hazard_Detected && !in_flush;
  assign IF_Flush        = !rst && (br_acc || in_flush);
  assign State           = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      fc_q        <= 3'd0;
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      if (Hazard_Detected && (Stall_Count != '1))
        Stall_Count <= Stall_Count + CNT_ONE;
      if (br_acc && (Flush_Count != '1))
        Flush_Count <= Flush_Count + CNT_ONE;

      case (state_q)
        ST_RUN, ST_STALL: begin
          if (Hazard_Detected) begin
            state_q <= ST_STALL;
          end else if (br_acc && (BR_FLUSH_CYCLES > 1)) begin
            state_q <= ST_FLUSH;
            fc_q    <= FC_INIT;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (fc_q == 3'd0)
            state_q <= ST_RUN;
          else
            fc_q <= fc_q - 3'd1;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_flush_controller.sv
module tb_hazard_flush_controller;

  localparam int BFC = 3;
  localparam int CW  = 16;

  logic          clk;
  logic          rst;
  logic          ID_Valid;
  logic [4:0]    src1;
  logic [4:0]    src2;
  logic          Two_Src;
  logic          Br_Taken;
  logic          Forward_EN;
  logic [4:0]    EXE_Dest;
  logic          EXE_WB_EN;
  logic          EXE_MEM_R_EN;
  logic [4:0]    MEM_Dest;
  logic          MEM_WB_EN;
  logic          Hazard_Detected;
  logic          IF_Flush;
  logic [1:0]    State;
  logic [CW-1:0] Stall_Count;
  logic [CW-1:0] Flush_Count;

  hazard_flush_controller #(.BR_FLUSH_CYCLES(BFC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ID_Valid(ID_Valid), .src1(src1), .src2(src2),
    .Two_Src(Two_Src), .Br_Taken(Br_Taken), .Forward_EN(Forward_EN),
    .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN),
    .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN),
    .Hazard_Detected(Hazard_Detected), .IF_Flush(IF_Flush), .State(State),
    .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mask bits: 0 hd, 1 if_flush, 2 state, 3 stall count, 4 flush count
  typedef struct {
    string       name;
    logic [4:0]  mask;
    logic        hd;
    logic        ifl;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [4:0] ALL = 5'h1f;

  // Push the expectation for the cycle now being driven, then advance.
  task automatic chk(input string name, input logic [4:0] mask, input logic hd,
                     input logic ifl, input logic [1:0] st, input logic [15:0] sc,
                     input logic [15:0] fc);
    exp_t e;
    e.name = name; e.mask = mask; e.hd = hd; e.ifl = ifl;
    e.st = st; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_Valid = 0; src1 = 0; src2 = 0; Two_Src = 0; Br_Taken = 0;
    Forward_EN = 0; EXE_Dest = 0; EXE_WB_EN = 0; EXE_MEM_R_EN = 0;
    MEM_Dest = 0; MEM_WB_EN = 0;
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.mask[0]) begin
        total++;
        if (Hazard_Detected !== e.hd) begin
          bad++;
          $display("FAIL %s hazard_detected got=%b want=%b", e.name, Hazard_Detected, e.hd);
        end
      end
      if (e.mask[1]) begin
        total++;
        if (IF_Flush !== e.ifl) begin
          bad++;
          $display("FAIL %s if_flush got=%b want=%b", e.name, IF_Flush, e.ifl);
        end
      end
      if (e.mask[2]) begin
        total++;
        if (State !== e.st) begin
          bad++;
          $display("FAIL %s state got=%0d want=%0d", e.name, State, e.st);
        end
      end
      if (e.mask[3]) begin
        total++;
        if (Stall_Count !== e.sc) begin
          bad++;
          $display("FAIL %s stall_count got=%0d want=%0d", e.name, Stall_Count, e.sc);
        end
      end
      if (e.mask[4]) begin
        total++;
        if (Flush_Count !== e.fc) begin
          bad++;
          $display("FAIL %s flush_count got=%0d want=%0d", e.name, Flush_Count, e.fc);
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    #1;

    // reset forces outputs low even with hazard and branch inputs present
    ID_Valid = 1; EXE_WB_EN = 1; EXE_Dest = 5; src1 = 5; Br_Taken = 1;
    chk("rst_force", ALL, 0, 0, 0, 0, 0);
    rst = 0; idle();
    chk("idle", ALL, 0, 0, 0, 0, 0);

    // EXE RAW hazard without forwarding, 3 cycles
    ID_Valid = 1; EXE_WB_EN = 1; EXE_Dest = 5; src1 = 5;
    chk("exe_hz1", ALL, 1, 0, 0, 0, 0);
    chk("exe_hz2", ALL, 1, 0, 1, 1, 0);
    chk("exe_hz3", ALL, 1, 0, 1, 2, 0);
    EXE_WB_EN = 0;
    chk("exe_clr", ALL, 0, 0, 1, 3, 0);
    idle();
    chk("exe_run", ALL, 0, 0, 0, 3, 0);

    // register 0 never hazards; bubble never hazards
    ID_Valid = 1; EXE_WB_EN = 1; EXE_Dest = 0; src1 = 0;
    chk("r0", ALL, 0, 0, 0, 3, 0);
    ID_Valid = 0; EXE_Dest = 5; src1 = 5;
    chk("bubble", ALL, 0, 0, 0, 3, 0);

    // MEM hazard through src2
    idle();
    ID_Valid = 1; MEM_WB_EN = 1; MEM_Dest = 9; src2 = 9; Two_Src = 1;
    chk("mem_src2", ALL, 1, 0, 0, 3, 0);
    Two_Src = 0;
    chk("mem_no2src", ALL, 0, 0, 1, 4, 0);
    idle();
    chk("mem_run", ALL, 0, 0, 0, 4, 0);

    // forwarding: only load-use stalls
    ID_Valid = 1; Forward_EN = 1; EXE_Dest = 7; EXE_WB_EN = 1; src2 = 7;
    Two_Src = 1; MEM_Dest = 7; MEM_WB_EN = 1;
    chk("fwd_alu", ALL, 0, 0, 0, 4, 0);
    EXE_MEM_R_EN = 1;
    chk("fwd_load", ALL, 1, 0, 0, 4, 0);
    Two_Src = 0;
    chk("fwd_1src", ALL, 0, 0, 1, 5, 0);
    idle();
    chk("fwd_run", ALL, 0, 0, 0, 5, 0);

    // taken branch: 3 flush cycles, re-branch and hazards ignored in FLUSH
    ID_Valid = 1; Br_Taken = 1;
    chk("br_acc", ALL, 0, 1, 0, 5, 0);
    EXE_WB_EN = 1; EXE_Dest = 4; src1 = 4;
    chk("br_fl2", ALL, 0, 1, 2, 5, 1);
    chk("br_fl3", ALL, 0, 1, 2, 5, 1);
    idle();
    chk("br_end", ALL, 0, 0, 0, 5, 1);

    // branch held off by a MEM hazard, accepted once it clears
    ID_Valid = 1; Br_Taken = 1; MEM_WB_EN = 1; MEM_Dest = 3; src1 = 3;
    chk("brhz1", ALL, 1, 0, 0, 5, 1);
    chk("brhz2", ALL, 1, 0, 1, 6, 1);
    MEM_WB_EN = 0;
    chk("brhz_acc", ALL, 0, 1, 1, 7, 1);
    idle();
    chk("brhz_fl2", ALL, 0, 1, 2, 7, 2);
    chk("brhz_fl3", ALL, 0, 1, 2, 7, 2);
    chk("brhz_end", ALL, 0, 0, 0, 7, 2);

    // reset in the 2nd flush cycle
    ID_Valid = 1; Br_Taken = 1;
    chk("rbr_acc", ALL, 0, 1, 0, 7, 2);
    idle(); rst = 1;
    chk("rbr_rst", ALL, 0, 0, 2, 7, 3);
    rst = 0;
    chk("rbr_after", ALL, 0, 0, 0, 0, 0);

    // flush completes even if ID goes invalid
    ID_Valid = 1; Br_Taken = 1;
    chk("iv_acc", ALL, 0, 1, 0, 0, 0);
    idle();
    chk("iv_fl2", ALL, 0, 1, 2, 0, 1);
    chk("iv_fl3", ALL, 0, 1, 2, 0, 1);
    chk("iv_end", ALL, 0, 0, 0, 0, 1);

    // long hazard: stall counter saturates at 0xFFFF
    ID_Valid = 1; EXE_WB_EN = 1; EXE_Dest = 12; src1 = 12;
    for (int i = 0; i < 65540; i++) begin
      if (i >= 65533)
        chk("sat", 5'b01000, 1, 0, 1, (i > 65535) ? 16'hffff : 16'(i), 1);
      else
        chk("sat", 5'b00000, 1, 0, 1, 0, 1);
    end
    idle();
    chk("sat_hold", ALL, 0, 0, 1, 16'hffff, 1);
    chk("sat_run", ALL, 0, 0, 0, 16'hffff, 1);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
